// File: rtl/mlb_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
// The period clamp keeps every channel's counter range at least two cycles long.
package mlb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam int MAX_W = 32;
  localparam logic [MAX_W-1:0] MIN_PERIOD = 32'd2;

  function automatic logic [MAX_W-1:0] clamp_period(input logic [MAX_W-1:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One blinker channel: period counter, active and shadow configuration, pending flag.
// Shadow values move to the active set only at a period boundary or while the channel is idle.
module blink_channel
  import mlb_pkg::*;
#(
  parameter int CNT_W      = 27,
  parameter int DEF_PERIOD = 50000000,
  parameter int DEF_HIGH   = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             pending,
  output logic             led,
  output logic             wrap,
  output logic             done
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(clamp_period(MAX_W'(DEF_PERIOD)));
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  mode_e            mode, mode_nxt;
  logic [CNT_W-1:0] period, period_nxt;
  logic [CNT_W-1:0] high, high_nxt;
  mode_e            sh_mode, sh_mode_nxt;
  logic [CNT_W-1:0] sh_period, sh_period_nxt;
  logic [CNT_W-1:0] sh_high, sh_high_nxt;
  logic             pending_nxt;
  logic             led_nxt, wrap_nxt, done_nxt;

  logic running;
  logic at_end;
  logic apply;

  // Only BLINK and ONESHOT advance the counter; everything else parks it at zero.
  assign running = en && ((mode == MODE_BLINK) || (mode == MODE_ONESHOT));
  assign at_end  = running && (cnt == (period - ONE));
  assign apply   = pending && (at_end || !running);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      mode      <= MODE_BLINK;
      period    <= DEF_P;
      high      <= DEF_H;
      sh_mode   <= MODE_BLINK;
      sh_period <= DEF_P;
      sh_high   <= DEF_H;
      pending   <= 1'b0;
      led       <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      mode      <= mode_nxt;
      period    <= period_nxt;
      high      <= high_nxt;
      sh_mode   <= sh_mode_nxt;
      sh_period <= sh_period_nxt;
      sh_high   <= sh_high_nxt;
      pending   <= pending_nxt;
      led       <= led_nxt;
      wrap      <= wrap_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    cnt_nxt       = cnt;
    mode_nxt      = mode;
    period_nxt    = period;
    high_nxt      = high;
    sh_mode_nxt   = sh_mode;
    sh_period_nxt = sh_period;
    sh_high_nxt   = sh_high;
    pending_nxt   = pending;

    // The top never raises load while pending is set, so load and apply cannot collide.
    if (load) begin
      sh_mode_nxt   = mode_e'(cfg_mode);
      sh_period_nxt = cfg_period;
      sh_high_nxt   = cfg_high;
      pending_nxt   = 1'b1;
    end

    if (!running || at_end) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + ONE;
    end

    if (at_end && (mode == MODE_ONESHOT)) begin
      mode_nxt = MODE_OFF;
    end

    if (apply) begin
      mode_nxt    = sh_mode;
      period_nxt  = CNT_W'(clamp_period(MAX_W'(sh_period)));
      high_nxt    = sh_high;
      pending_nxt = 1'b0;
      cnt_nxt     = '0;
    end
  end

  always_comb begin
    led_nxt  = 1'b0;
    wrap_nxt = 1'b0;
    done_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_ON: led_nxt = 1'b1;
        MODE_BLINK, MODE_ONESHOT: begin
          led_nxt  = (cnt < high);
          wrap_nxt = at_end;
          done_nxt = at_end && (mode == MODE_ONESHOT);
        end
        default: led_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multi_led_blinker.sv
// N-channel programmable LED blinker: config port decode plus one blink_channel per LED.
// Requests aimed at a nonexistent channel are acknowledged and discarded.
module multi_led_blinker
  import mlb_pkg::*;
#(
  parameter int CNT_W      = 27,
  parameter int NUM_CH     = 4,
  parameter int DEF_PERIOD = 50000000,
  parameter int DEF_HIGH   = 25000000,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] wrap,
  output logic [NUM_CH-1:0] done
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;

  // Ready depends only on the addressed channel, never on cfg_valid.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
    end
  end

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = cfg_valid && !pending[i] && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    blink_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en         (en[g]),
      .load       (load[g]),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .pending    (pending[g]),
      .led        (led[g]),
      .wrap       (wrap[g]),
      .done       (done[g])
    );
  end

endmodule
